// File: rtl/axi_lite_pmem_bridge.sv
// AXI4-Lite slave that turns single read/write transactions into one-cycle Pmem strobes,
// with programmable access latency and SLVERR for addresses outside the memory window.
module axi_lite_pmem_bridge #(
    parameter int unsigned RD_LAT   = 0,
    parameter int unsigned WR_LAT   = 0,
    parameter logic [63:0] MEM_BASE = 64'h8000_0000,
    parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ar_valid,
    output logic        ar_ready,
    input  logic [63:0] ar_addr,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [63:0] r_data,
    output logic [1:0]  r_resp,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [63:0] aw_addr,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [63:0] w_data,
    input  logic [7:0]  w_strb,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [1:0]  b_resp,
    output logic [63:0] pm_raddr,
    output logic        pm_rvalid,
    input  logic [63:0] pm_rdata,
    output logic [63:0] pm_waddr,
    output logic [63:0] pm_wdata,
    output logic [7:0]  pm_mask
);

    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlv   = 2'b10;
    localparam logic [64:0] MemEnd    = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    localparam logic [3:0]  RdCntInit = 4'(RD_LAT - 1);
    localparam logic [3:0]  WrCntInit = 4'(WR_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdAcc,
        StRdResp,
        StWrWait,
        StWrAcc,
        StWrResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  strb_q, strb_d;
    logic        inr_q, inr_d;
    logic [63:0] r_data_q, r_data_d;
    logic [1:0]  r_resp_q, r_resp_d;
    logic        r_valid_q, r_valid_d;
    logic [1:0]  b_resp_q, b_resp_d;
    logic        b_valid_q, b_valid_d;
    logic [63:0] pm_raddr_q, pm_raddr_d;
    logic        pm_rvalid_q, pm_rvalid_d;
    logic [63:0] pm_waddr_q, pm_waddr_d;
    logic [63:0] pm_wdata_q, pm_wdata_d;
    logic [7:0]  pm_mask_q, pm_mask_d;

    logic wr_req, idle, rd_go, wr_go;

    // 65-bit compare so that MEM_BASE + MEM_SIZE cannot wrap.
    function automatic logic in_range(input logic [63:0] a);
        return ({1'b0, a} >= {1'b0, MEM_BASE}) && ({1'b0, a} < MemEnd);
    endfunction

    assign wr_req   = aw_valid & w_valid;
    assign idle     = (state_q == StIdle) & ~reset;
    assign aw_ready = idle & wr_req;
    assign w_ready  = idle & wr_req;
    assign ar_ready = idle & ~wr_req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        inr_d       = inr_q;
        r_data_d    = r_data_q;
        r_resp_d    = r_resp_q;
        r_valid_d   = r_valid_q;
        b_resp_d    = b_resp_q;
        b_valid_d   = b_valid_q;
        pm_raddr_d  = pm_raddr_q;
        pm_rvalid_d = 1'b0;
        pm_waddr_d  = pm_waddr_q;
        pm_wdata_d  = pm_wdata_q;
        pm_mask_d   = 8'h00;
        rd_go       = 1'b0;
        wr_go       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (aw_ready) begin
                    addr_d  = aw_addr;
                    wdata_d = w_data;
                    strb_d  = w_strb;
                    inr_d   = in_range(aw_addr);
                    if (WR_LAT == 0) begin
                        state_d = StWrAcc;
                        wr_go   = 1'b1;
                    end else begin
                        state_d = StWrWait;
                        cnt_d   = WrCntInit;
                    end
                end else if (ar_valid && ar_ready) begin
                    addr_d = ar_addr;
                    inr_d  = in_range(ar_addr);
                    if (RD_LAT == 0) begin
                        state_d = StRdAcc;
                        rd_go   = 1'b1;
                    end else begin
                        state_d = StRdWait;
                        cnt_d   = RdCntInit;
                    end
                end
            end
            StRdWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRdAcc;
                    rd_go   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRdAcc: begin
                r_data_d  = inr_q ? pm_rdata : 64'h0;
                r_resp_d  = inr_q ? RespOkay : RespSlv;
                r_valid_d = 1'b1;
                state_d   = StRdResp;
            end
            StRdResp: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StWrWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWrAcc;
                    wr_go   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrAcc: begin
                b_resp_d  = inr_q ? RespOkay : RespSlv;
                b_valid_d = 1'b1;
                state_d   = StWrResp;
            end
            StWrResp: begin
                if (b_ready) begin
                    b_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pmem-side flops load on entry to the access state so the strobe is a clean flop output.
        if (rd_go) begin
            pm_raddr_d  = addr_d;
            pm_rvalid_d = inr_d;
        end
        if (wr_go && inr_d) begin
            pm_waddr_d = addr_d;
            pm_wdata_d = wdata_d;
            pm_mask_d  = strb_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 64'h0;
            wdata_q     <= 64'h0;
            strb_q      <= 8'h00;
            inr_q       <= 1'b0;
            r_data_q    <= 64'h0;
            r_resp_q    <= 2'b00;
            r_valid_q   <= 1'b0;
            b_resp_q    <= 2'b00;
            b_valid_q   <= 1'b0;
            pm_raddr_q  <= 64'h0;
            pm_rvalid_q <= 1'b0;
            pm_waddr_q  <= 64'h0;
            pm_wdata_q  <= 64'h0;
            pm_mask_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            inr_q       <= inr_d;
            r_data_q    <= r_data_d;
            r_resp_q    <= r_resp_d;
            r_valid_q   <= r_valid_d;
            b_resp_q    <= b_resp_d;
            b_valid_q   <= b_valid_d;
            pm_raddr_q  <= pm_raddr_d;
            pm_rvalid_q <= pm_rvalid_d;
            pm_waddr_q  <= pm_waddr_d;
            pm_wdata_q  <= pm_wdata_d;
            pm_mask_q   <= pm_mask_d;
        end
    end

    assign r_valid   = r_valid_q;
    assign r_data    = r_data_q;
    assign r_resp    = r_resp_q;
    assign b_valid   = b_valid_q;
    assign b_resp    = b_resp_q;
    assign pm_raddr  = pm_raddr_q;
    assign pm_rvalid = pm_rvalid_q;
    assign pm_waddr  = pm_waddr_q;
    assign pm_wdata  = pm_wdata_q;
    assign pm_mask   = pm_mask_q;

endmodule

// File: tb/tb_axi_lite_pmem_bridge.sv
// Scoreboard bench for axi_lite_pmem_bridge: a byte-level reference memory predicts responses
// and Pmem strobes at issue time; an independent monitor checks them as the DUT produces them.
module tb_axi_lite_pmem_bridge;

    localparam int unsigned RD_LAT = 0;
    localparam int unsigned WR_LAT = 2;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SIZE = 64'h0800_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [63:0] ar_addr, r_data;
    logic [1:0]  r_resp, b_resp;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [63:0] aw_addr, w_data;
    logic [7:0]  w_strb;
    logic [63:0] pm_raddr, pm_rdata, pm_waddr, pm_wdata;
    logic        pm_rvalid;
    logic [7:0]  pm_mask;

    axi_lite_pmem_bridge #(
        .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .MEM_BASE(BASE), .MEM_SIZE(SIZE)
    ) dut (
        .clock(clock), .reset(reset),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .pm_raddr(pm_raddr), .pm_rvalid(pm_rvalid), .pm_rdata(pm_rdata),
        .pm_waddr(pm_waddr), .pm_wdata(pm_wdata), .pm_mask(pm_mask)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Physical memory seen by the DUT; stimulus only touches words that map to distinct slots.
    logic [63:0] pmem [0:255];
    bit          mem_clr = 1'b1;
    always_comb pm_rdata = pm_rvalid ? pmem[pm_raddr[10:3]] : 64'h0;
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) pmem[i] <= 64'h0;
        end else if (pm_mask != 8'h00) begin
            for (int b = 0; b < 8; b++)
                if (pm_mask[b]) pmem[pm_waddr[10:3]][8*b +: 8] <= pm_wdata[8*b +: 8];
        end
    end

    typedef struct { bit wr; logic [63:0] data; logic [1:0] resp; int due; } rsp_t;
    typedef struct { bit wr; logic [63:0] addr; logic [63:0] data; logic [7:0] mask; int due; } pm_t;
    rsp_t rq[$];
    pm_t  pq[$];
    logic [7:0] ref_bytes [logic [63:0]];

    int checks = 0;
    int fails  = 0;
    int stall  = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_win(input logic [63:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + {1'b0, SIZE}));
    endfunction

    function automatic logic [63:0] ref_word(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++)
            w[8*i +: 8] = ref_bytes.exists(a + 64'(i)) ? ref_bytes[a + 64'(i)] : 8'h00;
        return w;
    endfunction

    task automatic model_read(input logic [63:0] a, input int t);
        rsp_t e;
        pm_t  p;
        bit   inw = in_win(a);
        e.wr = 1'b0; e.data = inw ? ref_word(a) : 64'h0;
        e.resp = inw ? 2'b00 : 2'b10; e.due = t + int'(RD_LAT) + 2;
        rq.push_back(e);
        if (inw) begin
            p.wr = 1'b0; p.addr = a; p.data = 64'h0; p.mask = 8'h00; p.due = t + int'(RD_LAT) + 1;
            pq.push_back(p);
        end
    endtask

    // Memory contents change only when the predicted write strobe is observed, so a write
    // dropped by reset leaves the reference untouched.
    task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                               input int t);
        rsp_t e;
        pm_t  p;
        bit   inw = in_win(a);
        e.wr = 1'b1; e.data = 64'h0; e.resp = inw ? 2'b00 : 2'b10; e.due = t + int'(WR_LAT) + 2;
        rq.push_back(e);
        if (inw && s != 8'h00) begin
            p.wr = 1'b1; p.addr = a; p.data = d; p.mask = s; p.due = t + int'(WR_LAT) + 1;
            pq.push_back(p);
        end
    endtask

    logic        r_pend = 1'b0, b_pend = 1'b0;
    logic [63:0] r_hold = 64'h0;
    logic [1:0]  rr_hold = 2'b00, b_hold = 2'b00;

    always @(negedge clock) begin : monitor
        rsp_t e;
        pm_t  p;
        if (reset) begin
            r_pend <= 1'b0;
            b_pend <= 1'b0;
        end else begin
            if (r_valid) begin
                if (!r_pend) begin
                    if (rq.size() == 0 || rq[0].wr) cmp("r_valid_spurious", 64'(r_valid), 64'h0);
                    else begin
                        e = rq.pop_front();
                        cmp("r_data", r_data, e.data);
                        cmp("r_resp", 64'(r_resp), 64'(e.resp));
                        cmp("r_valid_cycle", 64'(cyc), 64'(e.due));
                    end
                end else begin
                    cmp("r_data_stable", r_data, r_hold);
                    cmp("r_resp_stable", 64'(r_resp), 64'(rr_hold));
                end
                r_hold  <= r_data;
                rr_hold <= r_resp;
            end
            r_pend <= r_valid && !r_ready;

            if (b_valid) begin
                if (!b_pend) begin
                    if (rq.size() == 0 || !rq[0].wr) cmp("b_valid_spurious", 64'(b_valid), 64'h0);
                    else begin
                        e = rq.pop_front();
                        cmp("b_resp", 64'(b_resp), 64'(e.resp));
                        cmp("b_valid_cycle", 64'(cyc), 64'(e.due));
                    end
                end else begin
                    cmp("b_resp_stable", 64'(b_resp), 64'(b_hold));
                end
                b_hold <= b_resp;
            end
            b_pend <= b_valid && !b_ready;

            if (pm_rvalid) begin
                if (pq.size() == 0 || pq[0].wr) cmp("pm_rvalid_spurious", 64'(pm_rvalid), 64'h0);
                else begin
                    p = pq.pop_front();
                    cmp("pm_raddr", pm_raddr, p.addr);
                    cmp("pm_rvalid_cycle", 64'(cyc), 64'(p.due));
                end
            end

            if (pm_mask != 8'h00) begin
                if (pq.size() == 0 || !pq[0].wr) cmp("pm_mask_spurious", 64'(pm_mask), 64'h0);
                else begin
                    p = pq.pop_front();
                    cmp("pm_waddr", pm_waddr, p.addr);
                    cmp("pm_wdata", pm_wdata, p.data);
                    cmp("pm_mask", 64'(pm_mask), 64'(p.mask));
                    cmp("pm_mask_cycle", 64'(cyc), 64'(p.due));
                    for (int i = 0; i < 8; i++)
                        if (p.mask[i]) ref_bytes[p.addr + 64'(i)] = p.data[8*i +: 8];
                end
            end
        end
    end

    // Response-channel backpressure: random, or forced low while stall counts down.
    initial begin
        r_ready = 1'b0;
        b_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (stall > 0) begin
                r_ready = 1'b0;
                b_ready = 1'b0;
                stall   = stall - 1;
            end else begin
                r_ready = ($urandom_range(0, 3) != 0);
                b_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic rd(input logic [63:0] a);
        bit ok = 1'b0;
        @(posedge clock); #1;
        ar_addr = a; ar_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (ar_ready) begin
                model_read(a, cyc);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) cmp("ar_accept_timeout", 64'(ar_ready), 64'h1);
        @(posedge clock); #1;
        ar_valid = 1'b0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        bit ok = 1'b0;
        @(posedge clock); #1;
        aw_addr = a; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (aw_ready && w_ready) begin
                model_write(a, d, s, cyc);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) cmp("aw_accept_timeout", 64'(aw_ready), 64'h1);
        @(posedge clock); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (rq.size() == 0 && pq.size() == 0 && !r_valid && !b_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            cmp("drain_timeout", 64'(rq.size() + pq.size()), 64'h0);
            rq.delete();
            pq.delete();
        end
    endtask

    function automatic logic [63:0] rand_addr();
        unique case ($urandom_range(0, 3))
            0: return BASE + 64'(8 * $urandom_range(0, 127));
            1: return BASE + SIZE - 64'(8 * $urandom_range(1, 128));
            2: return BASE + SIZE + 64'(8 * $urandom_range(0, 1000));
            default: return 64'(8 * $urandom_range(0, 4096));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ar_valid = 1'b0; ar_addr = 64'h0;
        aw_valid = 1'b0; aw_addr = 64'h0;
        w_valid = 1'b0; w_data = 64'h0; w_strb = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        cmp("rst_r_valid", 64'(r_valid), 64'h0);
        cmp("rst_b_valid", 64'(b_valid), 64'h0);
        cmp("rst_ar_ready", 64'(ar_ready), 64'h0);
        cmp("rst_aw_ready", 64'(aw_ready), 64'h0);
        cmp("rst_pm_rvalid", 64'(pm_rvalid), 64'h0);
        cmp("rst_pm_mask", 64'(pm_mask), 64'h0);
        cmp("rst_r_data", r_data, 64'h0);
        cmp("rst_pm_waddr", pm_waddr, 64'h0);
        cmp("rst_pm_wdata", pm_wdata, 64'h0);
        cmp("rst_pm_raddr", pm_raddr, 64'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        mem_clr = 1'b0;

        // Basic read/write, partial strobe readback, zero strobe.
        wr(64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        rd(64'h8000_0008);
        wr(64'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F);
        rd(64'h8000_0010);
        wr(64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        rd(64'h8000_0018);

        // Window boundaries.
        rd(64'h0000_1000);
        wr(64'h8800_0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        wr(BASE + SIZE - 64'd8, 64'hA5A5_5A5A_0F0F_F0F0, 8'hF0);
        rd(BASE + SIZE - 64'd8);
        rd(BASE + SIZE);
        rd(BASE - 64'd8);
        rd(BASE);
        rd(64'hFFFF_FFFF_FFFF_FFF8);
        wait_idle();

        // Simultaneous read and write: write wins, then the read sees long backpressure.
        @(posedge clock); #1;
        ar_addr = 64'h8000_0020; ar_valid = 1'b1;
        aw_addr = 64'h8000_0020; w_data = 64'h0BAD_F00D_1234_5678; w_strb = 8'hFF;
        aw_valid = 1'b1; w_valid = 1'b1;
        @(negedge clock);
        cmp("prio_aw_ready", 64'(aw_ready), 64'h1);
        cmp("prio_w_ready", 64'(w_ready), 64'h1);
        cmp("prio_ar_ready", 64'(ar_ready), 64'h0);
        if (aw_ready && w_ready) model_write(aw_addr, w_data, w_strb, cyc);
        @(posedge clock); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        begin
            bit ok = 1'b0;
            for (int n = 0; n < 300; n++) begin
                @(negedge clock);
                if (ar_ready) begin
                    model_read(ar_addr, cyc);
                    stall = 8;
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) cmp("prio_ar_timeout", 64'(ar_ready), 64'h1);
        end
        @(posedge clock); #1;
        ar_valid = 1'b0;
        wait_idle();

        // Lone aw_valid is not accepted until w_valid joins it.
        @(posedge clock); #1;
        aw_addr = 64'h8000_0028; w_data = 64'hCAFE_0000_BABE_0000; w_strb = 8'h3C;
        aw_valid = 1'b1; w_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            cmp("lone_aw_ready", 64'(aw_ready), 64'h0);
            cmp("lone_w_ready", 64'(w_ready), 64'h0);
            @(posedge clock); #1;
        end
        w_valid = 1'b1;
        @(negedge clock);
        cmp("join_aw_ready", 64'(aw_ready), 64'h1);
        if (aw_ready) model_write(aw_addr, w_data, w_strb, cyc);
        @(posedge clock); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        rd(64'h8000_0028);
        wait_idle();

        // Reset while the write is still waiting: it must vanish without a strobe or response.
        wr(64'h8000_0030, 64'h7777_6666_5555_4444, 8'hFF);
        reset = 1'b1;
        rq.delete();
        pq.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        cmp("rstmid_b_valid", 64'(b_valid), 64'h0);
        cmp("rstmid_pm_mask", 64'(pm_mask), 64'h0);
        cmp("rstmid_idle_ar_ready", 64'(ar_ready), 64'h1);
        repeat (6) @(negedge clock);
        rd(64'h8000_0030);
        wait_idle();

        // Random traffic.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 0) rd(rand_addr());
            else wr(rand_addr(), {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
        end
        wait_idle();
        cmp("rq_empty", 64'(rq.size()), 64'h0);
        cmp("pq_empty", 64'(pq.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
